// File: rtl/quantum_arbiter.sv
// Round-robin arbiter that grants one requester at a time, bounded by a slot quantum.
// Optional macro QUANTUM_ARB_PREEMPT_EN enables forced preemption/renewal on quantum expiry.
module quantum_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int QUANTUM = 31,
  parameter int CW      = $clog2(QUANTUM + 1),
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_id,
  output logic               busy,
  output logic [CW-1:0]      slot_count,
  output logic               expired,
  output logic               preempt,
  output logic               state_dbg
);

  // Handshake: a requester holds req high until it sees its grant bit; it keeps
  // req high while using the resource and ends its slot by pulsing done (or dropping req).
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic                found;
  logic [IW-1:0]       win;
  logic [IW-1:0]       cand;
  int                  idx;
  logic                voluntary;
  logic                others;
  logic [IW-1:0]       ptr_next;

  // Search upward from ptr with wrap-around for the first pending request.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign expired   = busy && (slot_count == CW'(QUANTUM));
  assign voluntary = done[grant_id] || !req[grant_id];
  assign others    = |(req & ~grant);
  assign ptr_next  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
  assign state_dbg = (state == GRANT);

`ifdef QUANTUM_ARB_PREEMPT_EN
  logic preempt_q;
  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      slot_count <= '0;
      ptr        <= '0;
`ifdef QUANTUM_ARB_PREEMPT_EN
      preempt_q  <= 1'b0;
`endif
    end else begin
`ifdef QUANTUM_ARB_PREEMPT_EN
      preempt_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            state      <= GRANT;
            grant      <= NUM_REQ'(1) << win;
            grant_id   <= win;
            busy       <= 1'b1;
            slot_count <= '0;
          end
        end
        GRANT: begin
          // Voluntary release wins over expiry; release always passes through IDLE.
          if (voluntary) begin
            state      <= IDLE;
            grant      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            slot_count <= '0;
            ptr        <= ptr_next;
          end
`ifdef QUANTUM_ARB_PREEMPT_EN
          else if (expired && others) begin
            state      <= IDLE;
            grant      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            slot_count <= '0;
            ptr        <= ptr_next;
            preempt_q  <= 1'b1;
          end else if (expired) begin
            slot_count <= '0;
          end else begin
            slot_count <= slot_count + CW'(1);
          end
`else
          else if (slot_count != CW'(QUANTUM)) begin
            slot_count <= slot_count + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_arbiter.sv
// Directed bench for quantum_arbiter (NUM_REQ=4, QUANTUM=3) with a queue-based scoreboard.
// Expectations for expiry adapt to whether QUANTUM_ARB_PREEMPT_EN is defined.
module tb_quantum_arbiter;
  localparam int NUM_REQ = 4;
  localparam int QUANTUM = 3;
  localparam int CW = 2;
  localparam int IW = 2;
  localparam int W  = NUM_REQ + IW + 1 + CW + 1 + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] done = '0;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_id;
  logic               busy;
  logic [CW-1:0]      slot_count;
  logic               expired;
  logic               preempt;
  logic               state_dbg;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           vec_id = 0;
  int           n_cmp = 0;
  int           n_fail = 0;

  quantum_arbiter #(.NUM_REQ(NUM_REQ), .QUANTUM(QUANTUM)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant),
    .grant_id(grant_id), .busy(busy), .slot_count(slot_count),
    .expired(expired), .preempt(preempt), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Monitor: compare the DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      int           t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {grant, grant_id, busy, slot_count, expired, preempt};
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL vec%0d {grant,id,busy,slot,expired,preempt}: got %b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b",
                 t, got[10:7], got[6:5], got[4], got[3:2], got[1], got[0],
                 e[10:7], e[6:5], e[4], e[3:2], e[1], e[0]);
      end
    end
  end

  // Driver: apply inputs, let one edge pass, push the hand-computed response
  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                     input logic [1:0] eid, input logic [1:0] es, input logic ep);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
    exp_q.push_back({eg, eid, |eg, es, (|eg) && (es == 2'd3), ep});
    tag_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic check_now(input string name);
    logic [W-1:0] got;
    got = {grant, grant_id, busy, slot_count, expired, preempt};
    n_cmp++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s: got %b want all zero", name, got);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    req  = '0;
    done = '0;
    rst  = 1'b1;
    #1;
    check_now("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] hold;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset, then a single request
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd0, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd1, 1'b0);
    cyc(4'b0100, 4'b0100, 4'b0000, 2'd0, 2'd0, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);

    // Round-robin fairness: order 0,1,2,3,0 with an idle gap each time
    apply_reset();
    for (int h = 0; h < 5; h++) begin
      hold = 4'(1 << (h % 4));
      cyc(4'b1111, (h == 0) ? 4'b1111 : 4'b0000, hold, 2'(h % 4), 2'd0, 1'b0);
      cyc(4'b1111, ~hold, hold, 2'(h % 4), 2'd1, 1'b0);
      cyc(4'b1111, hold, 4'b0000, 2'd0, 2'd0, 1'b0);
    end

    // Pointer wrap: holder 3 releases with req=1001, then 0, then 3
    cyc(4'b1000, 4'b0000, 4'b1000, 2'd3, 2'd0, 1'b0);
    cyc(4'b1001, 4'b1000, 4'b0000, 2'd0, 2'd0, 1'b0);
    cyc(4'b1001, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
    cyc(4'b1001, 4'b0001, 4'b0000, 2'd0, 2'd0, 1'b0);
    cyc(4'b1001, 4'b0000, 4'b1000, 2'd3, 2'd0, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);

    // Expiry with a competing requester
    cyc(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
    cyc(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd1, 1'b0);
    cyc(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd2, 1'b0);
    cyc(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
`ifdef QUANTUM_ARB_PREEMPT_EN
    cyc(4'b0011, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b1);
    cyc(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd0, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0000, 2'd0, 2'd0, 1'b0);
`else
    cyc(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
    cyc(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
    cyc(4'b0011, 4'b0001, 4'b0000, 2'd0, 2'd0, 1'b0);
`endif
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);

    // Expiry with no competitor
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd1, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd2, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
`ifdef QUANTUM_ARB_PREEMPT_EN
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd1, 1'b0);
`else
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
`endif
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);

    // done coincides with expiry while another requester waits: plain release
    cyc(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd0, 1'b0);
    cyc(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd1, 1'b0);
    cyc(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd2, 1'b0);
    cyc(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd3, 1'b0);
    cyc(4'b0011, 4'b0010, 4'b0000, 2'd0, 2'd0, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);

    // Asynchronous reset mid-grant, then search restarts at ptr 0
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd0, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2, 2'd1, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_now("async_reset_mid_grant");
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0110, 4'b0000, 4'b0010, 2'd1, 2'd0, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
